// File: rtl/rossler_pkg.sv
// Shared types and helpers for the Rossler oscillator: FSM encoding,
// default coefficients, fixed-point range limits and saturating add/negate.
package rossler_pkg;

    // Working width for the saturating helpers; Width up to 63 fits exactly.
    localparam int MAX_W = 64;

    typedef logic signed [MAX_W-1:0] wide_t;

    // Saturating result: value plus a flag that clamping took place.
    typedef struct packed {
        logic  sat;
        wide_t v;
    } sat_res_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MUL_AY  = 2'd1,
        S_MUL_ZXC = 2'd2,
        S_UPDATE  = 2'd3
    } state_t;

    // Default build: Q11.21 words, h = 2^-8, coefficients a=b=0.2, c=5.7, x0=1.0.
    localparam int DEF_WIDTH     = 32;
    localparam int DEF_FRAC_BITS = 21;
    localparam int DEF_HSHIFT    = 8;
    localparam int DEF_A         = 419430;
    localparam int DEF_B         = 419430;
    localparam int DEF_C         = 11953766;
    localparam int DEF_X         = 2097152;

    // Largest value of a w-bit signed word.
    function automatic wide_t fxp_max(input int w);
        return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    endfunction

    // Most negative value of a w-bit signed word.
    function automatic wide_t fxp_min(input int w);
        return -(wide_t'(1) <<< (w - 1));
    endfunction

    // Clamp an exact wide value into the w-bit signed range.
    function automatic sat_res_t clamp_w(input wide_t v, input int w);
        sat_res_t r;
        r.sat = 1'b0;
        r.v   = v;
        if (v > fxp_max(w)) begin
            r.v   = fxp_max(w);
            r.sat = 1'b1;
        end else if (v < fxp_min(w)) begin
            r.v   = fxp_min(w);
            r.sat = 1'b1;
        end
        return r;
    endfunction

    // Saturating add of two w-bit values held sign-extended in wide_t.
    function automatic sat_res_t addsat(input wide_t a, input wide_t b, input int w);
        return clamp_w(a + b, w);
    endfunction

    // Saturating negate: -MIN clamps to MAX.
    function automatic sat_res_t negsat(input wide_t v, input int w);
        return clamp_w(-v, w);
    endfunction

endpackage

// File: rtl/rossler_gen_if.sv
// Control, configuration and sample bus of the Rossler oscillator.
interface rossler_gen_if #(
    parameter int Width = 32
);
    logic                    start_i;
    logic                    load_i;
    logic signed [Width-1:0] a_i;
    logic signed [Width-1:0] b_i;
    logic signed [Width-1:0] c_i;
    logic signed [Width-1:0] x0_i;
    logic signed [Width-1:0] y0_i;
    logic signed [Width-1:0] z0_i;
    logic signed [Width-1:0] xn_o;
    logic signed [Width-1:0] yn_o;
    logic signed [Width-1:0] zn_o;
    logic                    valid_o;
    logic                    busy_o;
    logic                    sat_o;

    // Host side: drives control and configuration, receives samples.
    modport master (
        output start_i, load_i, a_i, b_i, c_i, x0_i, y0_i, z0_i,
        input  xn_o, yn_o, zn_o, valid_o, busy_o, sat_o
    );

    // Oscillator side.
    modport slave (
        input  start_i, load_i, a_i, b_i, c_i, x0_i, y0_i, z0_i,
        output xn_o, yn_o, zn_o, valid_o, busy_o, sat_o
    );
endinterface

// File: rtl/rossler_gen_fxp_mul_sat.sv
// Signed fixed-point multiplier: full-width product, rescale by FracBits
// with truncation toward -inf, saturate to the Width-bit range.
module fxp_mul_sat #(
    parameter int Width    = 32,
    parameter int FracBits = 21
) (
    input  logic signed [Width-1:0] a_i,
    input  logic signed [Width-1:0] b_i,
    output logic signed [Width-1:0] p_o,
    output logic                    ovf_o
);
    localparam int PW = 2 * Width;

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] scaled;
    logic [PW-Width:0]    top_bits;

    // Product fits in Width bits only if every bit above the kept sign bit matches it.
    always_comb begin
        a_ext    = PW'(a_i);
        b_ext    = PW'(b_i);
        prod     = a_ext * b_ext;
        scaled   = prod >>> FracBits;
        top_bits = scaled[PW-1:Width-1];
        ovf_o    = !((&top_bits) || !(|top_bits));
        if (!ovf_o) begin
            p_o = scaled[Width-1:0];
        end else if (prod[PW-1]) begin
            p_o = {1'b1, {(Width-1){1'b0}}};
        end else begin
            p_o = {1'b0, {(Width-1){1'b1}}};
        end
    end
endmodule

// File: rtl/rossler_gen.sv
// Rossler oscillator, forward-Euler integration in signed fixed point.
// One iteration = MUL_AY, MUL_ZXC, UPDATE; a single multiplier is shared
// between the two product steps. Samples are published every Decim iterations.
module rossler_gen
    import rossler_pkg::*;
#(
    parameter int Width    = DEF_WIDTH,
    parameter int FracBits = DEF_FRAC_BITS,
    parameter int HShift   = DEF_HSHIFT,
    parameter int Decim    = 1,
    parameter int AInit    = DEF_A,
    parameter int BInit    = DEF_B,
    parameter int CInit    = DEF_C,
    parameter int XInit    = DEF_X
) (
    input  logic          clk_i,
    input  logic          rst_i,
    rossler_gen_if.slave  bus
);
    localparam int CntW = (Decim > 1) ? $clog2(Decim) : 1;
    localparam logic [CntW-1:0] CNT_LAST = CntW'(Decim - 1);

    localparam logic signed [Width-1:0] A_RST = Width'(AInit);
    localparam logic signed [Width-1:0] B_RST = Width'(BInit);
    localparam logic signed [Width-1:0] C_RST = Width'(CInit);
    localparam logic signed [Width-1:0] X_RST = Width'(XInit);

    function automatic wide_t widen(input logic signed [Width-1:0] v);
        return wide_t'(v);
    endfunction

    function automatic logic signed [Width-1:0] narrow(input wide_t v);
        return v[Width-1:0];
    endfunction

    // Euler step h = 2^-HShift as an arithmetic shift (floor).
    function automatic wide_t ash(input wide_t v);
        return v >>> HShift;
    endfunction

    state_t state_q, state_d;

    logic signed [Width-1:0] a_q, b_q, c_q;
    logic signed [Width-1:0] x_q, y_q, z_q;
    logic signed [Width-1:0] p1_q, p2_q;
    logic signed [Width-1:0] xn_q, yn_q, zn_q;
    logic                    valid_q;
    logic                    sat_q;
    logic [CntW-1:0]         cnt_q;

    logic signed [Width-1:0] mul_a, mul_b, mul_p;
    logic                    mul_ovf;

    sat_res_t neg_c, diff, neg_y, neg_z, sum_x, sum_y, sum_z, nx, ny, nz;
    logic signed [Width-1:0] d_val, x_new, y_new, z_new;
    logic                    d_sat, upd_sat, sat_evt;
    logic                    load_ok, publish;

    fxp_mul_sat #(
        .Width    (Width),
        .FracBits (FracBits)
    ) u_mul (
        .a_i   (mul_a),
        .b_i   (mul_b),
        .p_o   (mul_p),
        .ovf_o (mul_ovf)
    );

    // Iteration sequencing; a load in IDLE takes priority over start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (!bus.load_i && bus.start_i) state_d = S_MUL_AY;
            S_MUL_AY:  state_d = S_MUL_ZXC;
            S_MUL_ZXC: state_d = S_UPDATE;
            S_UPDATE:  state_d = bus.start_i ? S_MUL_AY : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Shared multiplier operands: a*y first, then z*(x-c).
    always_comb begin
        mul_a = z_q;
        mul_b = d_val;
        if (state_q == S_MUL_AY) begin
            mul_a = a_q;
            mul_b = y_q;
        end
    end

    // Saturating datapath; every update term is built from the old x, y, z.
    always_comb begin
        neg_c   = negsat(widen(c_q), Width);
        diff    = addsat(widen(x_q), neg_c.v, Width);
        d_val   = narrow(diff.v);
        d_sat   = neg_c.sat | diff.sat;

        neg_y   = negsat(widen(y_q), Width);
        neg_z   = negsat(widen(z_q), Width);
        sum_x   = addsat(neg_y.v, neg_z.v, Width);
        nx      = addsat(widen(x_q), ash(sum_x.v), Width);

        sum_y   = addsat(widen(x_q), widen(p1_q), Width);
        ny      = addsat(widen(y_q), ash(sum_y.v), Width);

        sum_z   = addsat(widen(b_q), widen(p2_q), Width);
        nz      = addsat(widen(z_q), ash(sum_z.v), Width);

        x_new   = narrow(nx.v);
        y_new   = narrow(ny.v);
        z_new   = narrow(nz.v);
        upd_sat = neg_y.sat | neg_z.sat | sum_x.sat | nx.sat
                | sum_y.sat | ny.sat | sum_z.sat | nz.sat;
    end

    // Saturation events only count in the state that actually uses the result.
    always_comb begin
        sat_evt = 1'b0;
        case (state_q)
            S_MUL_AY:  sat_evt = mul_ovf;
            S_MUL_ZXC: sat_evt = mul_ovf | d_sat;
            S_UPDATE:  sat_evt = upd_sat;
            default:   sat_evt = 1'b0;
        endcase
        load_ok = (state_q == S_IDLE) && bus.load_i;
        publish = (state_q == S_UPDATE) && (cnt_q == CNT_LAST);
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Coefficients and integrator state: loaded in IDLE, advanced in UPDATE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q <= A_RST;
            b_q <= B_RST;
            c_q <= C_RST;
            x_q <= X_RST;
            y_q <= '0;
            z_q <= '0;
        end else if (load_ok) begin
            a_q <= bus.a_i;
            b_q <= bus.b_i;
            c_q <= bus.c_i;
            x_q <= bus.x0_i;
            y_q <= bus.y0_i;
            z_q <= bus.z0_i;
        end else if (state_q == S_UPDATE) begin
            x_q <= x_new;
            y_q <= y_new;
            z_q <= z_new;
        end
    end

    // Product registers for the two multiply steps.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p1_q <= '0;
            p2_q <= '0;
        end else if (state_q == S_MUL_AY) begin
            p1_q <= mul_p;
        end else if (state_q == S_MUL_ZXC) begin
            p2_q <= mul_p;
        end
    end

    // Decimator and published samples; a load shows x0/y0/z0 without a strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            xn_q    <= X_RST;
            yn_q    <= '0;
            zn_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= publish;
            if (load_ok) begin
                cnt_q <= '0;
                xn_q  <= bus.x0_i;
                yn_q  <= bus.y0_i;
                zn_q  <= bus.z0_i;
            end else if (state_q == S_UPDATE) begin
                cnt_q <= publish ? '0 : cnt_q + 1'b1;
                if (publish) begin
                    xn_q <= x_new;
                    yn_q <= y_new;
                    zn_q <= z_new;
                end
            end
        end
    end

    // Sticky saturation flag, cleared only by reset or an accepted load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        sat_q <= 1'b0;
        else if (load_ok) sat_q <= 1'b0;
        else if (sat_evt) sat_q <= 1'b1;
    end

    assign bus.xn_o    = xn_q;
    assign bus.yn_o    = yn_q;
    assign bus.zn_o    = zn_q;
    assign bus.valid_o = valid_q;
    assign bus.busy_o  = (state_q != S_IDLE);
    assign bus.sat_o   = sat_q;
endmodule

// File: tb/tb_rossler_gen.sv
// Bench for rossler_gen: a Decim=1 and a Decim=4 instance, checked against a
// plain-arithmetic model of the saturating Euler step.
module tb_rossler_gen;
    localparam int W = 32;
    localparam int F = 21;
    localparam int H = 8;
    localparam longint MAXL = 64'sd2147483647;
    localparam longint MINL = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rossler_gen_if #(.Width(W)) bus1 ();
    rossler_gen_if #(.Width(W)) bus4 ();

    rossler_gen #(.Width(W), .FracBits(F), .HShift(H), .Decim(1)) dut1 (
        .clk_i (clk), .rst_i (rst), .bus (bus1)
    );
    rossler_gen #(.Width(W), .FracBits(F), .HShift(H), .Decim(4)) dut4 (
        .clk_i (clk), .rst_i (rst), .bus (bus4)
    );

    int nvec = 0;
    int nerr = 0;

    longint mx, my, mz, ma, mb, mc;
    bit     msat;

    function automatic longint clampl(input longint v);
        if (v > MAXL) begin msat = 1'b1; return MAXL; end
        if (v < MINL) begin msat = 1'b1; return MINL; end
        return v;
    endfunction

    function automatic longint fmul(input longint p, input longint q);
        return clampl((p * q) >>> F);
    endfunction

    function automatic longint fneg(input longint v);
        return clampl(-v);
    endfunction

    function automatic longint fadd(input longint p, input longint q);
        return clampl(p + q);
    endfunction

    // One Euler iteration of the Rossler system with the old x, y, z.
    task automatic model_step();
        longint p1, d, p2, nx, ny, nz;
        p1 = fmul(ma, my);
        d  = fadd(mx, fneg(mc));
        p2 = fmul(mz, d);
        nx = fadd(mx, fadd(fneg(my), fneg(mz)) >>> H);
        ny = fadd(my, fadd(mx, p1) >>> H);
        nz = fadd(mz, fadd(mb, p2) >>> H);
        mx = nx; my = ny; mz = nz;
    endtask

    task automatic model_reset();
        mx = 2097152; my = 0; mz = 0;
        ma = 419430; mb = 419430; mc = 11953766;
        msat = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load1(input int a, input int b, input int c,
                         input int x, input int y, input int z);
        bus1.a_i = a; bus1.b_i = b; bus1.c_i = c;
        bus1.x0_i = x; bus1.y0_i = y; bus1.z0_i = z;
        bus1.load_i = 1'b1;
        tick();
        bus1.load_i = 1'b0;
        ma = a; mb = b; mc = c; mx = x; my = y; mz = z; msat = 1'b0;
    endtask

    // Drop start and let the running iteration finish, keeping the model in step.
    task automatic drain1(output int nv, output bit idle_ok);
        nv = 0;
        idle_ok = 1'b0;
        bus1.start_i = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus1.valid_o === 1'b1) begin
                nv++;
                model_step();
            end
            if (bus1.busy_o === 1'b0) begin
                idle_ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus1.start_i = 0; bus1.load_i = 0;
        bus1.a_i = 0; bus1.b_i = 0; bus1.c_i = 0; bus1.x0_i = 0; bus1.y0_i = 0; bus1.z0_i = 0;
        bus4.start_i = 0; bus4.load_i = 0;
        bus4.a_i = 0; bus4.b_i = 0; bus4.c_i = 0; bus4.x0_i = 0; bus4.y0_i = 0; bus4.z0_i = 0;
        rst = 1'b1;
        tick(); tick();
        nvec++; if (bus1.xn_o !== 32'h00200000) begin nerr++; $display("FAIL reset_xn: got %h want 00200000", bus1.xn_o); end
        nvec++; if (bus1.yn_o !== 32'h0) begin nerr++; $display("FAIL reset_yn: got %h want 0", bus1.yn_o); end
        nvec++; if (bus1.zn_o !== 32'h0) begin nerr++; $display("FAIL reset_zn: got %h want 0", bus1.zn_o); end
        nvec++; if (bus1.valid_o !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", bus1.valid_o); end
        nvec++; if (bus1.busy_o !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", bus1.busy_o); end
        nvec++; if (bus1.sat_o !== 1'b0) begin nerr++; $display("FAIL reset_sat: got %b want 0", bus1.sat_o); end
        nvec++; if (bus4.xn_o !== 32'h00200000) begin nerr++; $display("FAIL reset4_xn: got %h want 00200000", bus4.xn_o); end
        rst = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_defaults();
        logic exp_v;
        bit first;
        first = 1'b1;
        bus1.start_i = 1'b1;
        for (int k = 1; k <= 43; k++) begin
            tick();
            exp_v = (k >= 4) && (((k - 4) % 3) == 0);
            nvec++; if (bus1.valid_o !== exp_v) begin nerr++; $display("FAIL defaults_valid@%0d: got %b want %b", k, bus1.valid_o, exp_v); end
            if (k == 1) begin
                nvec++; if (bus1.busy_o !== 1'b1) begin nerr++; $display("FAIL defaults_busy: got %b want 1", bus1.busy_o); end
            end
            if (exp_v) begin
                model_step();
                if (first) begin
                    first = 1'b0;
                    nvec++; if (bus1.xn_o !== 32'h00200000) begin nerr++; $display("FAIL first_xn: got %h want 00200000", bus1.xn_o); end
                    nvec++; if (bus1.yn_o !== 32'h00002000) begin nerr++; $display("FAIL first_yn: got %h want 00002000", bus1.yn_o); end
                    nvec++; if (bus1.zn_o !== 32'h00000666) begin nerr++; $display("FAIL first_zn: got %h want 00000666", bus1.zn_o); end
                end
                nvec++; if (bus1.xn_o !== mx[31:0]) begin nerr++; $display("FAIL defaults_xn@%0d: got %0d want %0d", k, bus1.xn_o, mx); end
                nvec++; if (bus1.yn_o !== my[31:0]) begin nerr++; $display("FAIL defaults_yn@%0d: got %0d want %0d", k, bus1.yn_o, my); end
                nvec++; if (bus1.zn_o !== mz[31:0]) begin nerr++; $display("FAIL defaults_zn@%0d: got %0d want %0d", k, bus1.zn_o, mz); end
                nvec++; if (bus1.sat_o !== msat) begin nerr++; $display("FAIL defaults_sat@%0d: got %b want %b", k, bus1.sat_o, msat); end
            end
        end
    endtask

    // Entered with the FSM in MUL_AY: exactly one more sample, then idle.
    task automatic test_stop_midrun();
        int nv;
        bit idle_ok;
        drain1(nv, idle_ok);
        nvec++; if (nv != 1) begin nerr++; $display("FAIL stop_count: got %0d want 1", nv); end
        nvec++; if (!idle_ok || bus1.busy_o !== 1'b0) begin nerr++; $display("FAIL stop_busy: got %b want 0", bus1.busy_o); end
        nvec++; if (bus1.xn_o !== mx[31:0]) begin nerr++; $display("FAIL stop_xn: got %0d want %0d", bus1.xn_o, mx); end
        nvec++; if (bus1.yn_o !== my[31:0]) begin nerr++; $display("FAIL stop_yn: got %0d want %0d", bus1.yn_o, my); end
        nvec++; if (bus1.zn_o !== mz[31:0]) begin nerr++; $display("FAIL stop_zn: got %0d want %0d", bus1.zn_o, mz); end
    endtask

    // Resumes from the retained state while hammering load_i with junk.
    task automatic test_load_busy();
        int nv, nd;
        bit idle_ok;
        nv = 0;
        bus1.start_i = 1'b1;
        tick();
        for (int k = 1; k <= 24; k++) begin
            if (k <= 15) begin
                bus1.load_i = 1'b1;
                bus1.a_i = int'($urandom); bus1.b_i = int'($urandom); bus1.c_i = int'($urandom);
                bus1.x0_i = int'($urandom); bus1.y0_i = int'($urandom); bus1.z0_i = int'($urandom);
            end else begin
                bus1.load_i = 1'b0;
            end
            tick();
            if (bus1.valid_o === 1'b1) begin
                nv++;
                model_step();
                nvec++; if (bus1.xn_o !== mx[31:0]) begin nerr++; $display("FAIL busyload_xn@%0d: got %0d want %0d", k, bus1.xn_o, mx); end
                nvec++; if (bus1.yn_o !== my[31:0]) begin nerr++; $display("FAIL busyload_yn@%0d: got %0d want %0d", k, bus1.yn_o, my); end
                nvec++; if (bus1.zn_o !== mz[31:0]) begin nerr++; $display("FAIL busyload_zn@%0d: got %0d want %0d", k, bus1.zn_o, mz); end
            end
        end
        bus1.load_i = 1'b0;
        nvec++; if (nv != 8) begin nerr++; $display("FAIL busyload_count: got %0d want 8", nv); end
        drain1(nd, idle_ok);
        nvec++; if (!idle_ok) begin nerr++; $display("FAIL busyload_idle: got busy want idle"); end
    endtask

    task automatic test_random_golden();
        int a, b, c, x, y, z, nv, nd;
        bit idle_ok;
        for (int r = 0; r < 7; r++) begin
            if (r < 6) begin
                a = int'($urandom_range(1048576)) - 524288;
                b = int'($urandom_range(1048576)) - 524288;
                c = int'($urandom_range(16777216));
                x = int'($urandom_range(16777216)) - 8388608;
                y = int'($urandom_range(16777216)) - 8388608;
                z = int'($urandom_range(16777216)) - 8388608;
            end else begin
                a = int'($urandom); b = int'($urandom); c = int'($urandom);
                x = int'($urandom); y = int'($urandom); z = int'($urandom);
            end
            load1(a, b, c, x, y, z);
            nvec++; if (bus1.xn_o !== x) begin nerr++; $display("FAIL load_xn r%0d: got %0d want %0d", r, bus1.xn_o, x); end
            nvec++; if (bus1.yn_o !== y) begin nerr++; $display("FAIL load_yn r%0d: got %0d want %0d", r, bus1.yn_o, y); end
            nvec++; if (bus1.zn_o !== z) begin nerr++; $display("FAIL load_zn r%0d: got %0d want %0d", r, bus1.zn_o, z); end
            nvec++; if (bus1.valid_o !== 1'b0) begin nerr++; $display("FAIL load_valid r%0d: got %b want 0", r, bus1.valid_o); end
            nvec++; if (bus1.busy_o !== 1'b0) begin nerr++; $display("FAIL load_busy r%0d: got %b want 0", r, bus1.busy_o); end
            nvec++; if (bus1.sat_o !== 1'b0) begin nerr++; $display("FAIL load_sat r%0d: got %b want 0", r, bus1.sat_o); end
            nv = 0;
            bus1.start_i = 1'b1;
            for (int k = 1; k <= 61; k++) begin
                tick();
                if (bus1.valid_o === 1'b1) begin
                    nv++;
                    model_step();
                    nvec++; if (bus1.xn_o !== mx[31:0]) begin nerr++; $display("FAIL golden_xn r%0d@%0d: got %0d want %0d", r, k, bus1.xn_o, mx); end
                    nvec++; if (bus1.yn_o !== my[31:0]) begin nerr++; $display("FAIL golden_yn r%0d@%0d: got %0d want %0d", r, k, bus1.yn_o, my); end
                    nvec++; if (bus1.zn_o !== mz[31:0]) begin nerr++; $display("FAIL golden_zn r%0d@%0d: got %0d want %0d", r, k, bus1.zn_o, mz); end
                    nvec++; if (bus1.sat_o !== msat) begin nerr++; $display("FAIL golden_sat r%0d@%0d: got %b want %b", r, k, bus1.sat_o, msat); end
                end
            end
            nvec++; if (nv != 20) begin nerr++; $display("FAIL golden_count r%0d: got %0d want 20", r, nv); end
            drain1(nd, idle_ok);
            nvec++; if (!idle_ok) begin nerr++; $display("FAIL golden_idle r%0d: got busy want idle", r); end
        end
    endtask

    task automatic test_saturation();
        int nd;
        bit idle_ok, first;
        first = 1'b1;
        load1(32'h7FFFFFFF, 419430, 11953766, 32'h7FFFFF00, 32'h80000000, 32'h80000000);
        bus1.start_i = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (bus1.valid_o === 1'b1) begin
                model_step();
                if (first) begin
                    first = 1'b0;
                    nvec++; if (bus1.xn_o !== 32'h7FFFFFFF) begin nerr++; $display("FAIL sat_clamp_xn: got %h want 7fffffff", bus1.xn_o); end
                    nvec++; if (bus1.sat_o !== 1'b1) begin nerr++; $display("FAIL sat_flag: got %b want 1", bus1.sat_o); end
                end
                nvec++; if (bus1.xn_o !== mx[31:0]) begin nerr++; $display("FAIL sat_xn@%0d: got %0d want %0d", k, bus1.xn_o, mx); end
                nvec++; if (bus1.yn_o !== my[31:0]) begin nerr++; $display("FAIL sat_yn@%0d: got %0d want %0d", k, bus1.yn_o, my); end
                nvec++; if (bus1.zn_o !== mz[31:0]) begin nerr++; $display("FAIL sat_zn@%0d: got %0d want %0d", k, bus1.zn_o, mz); end
                nvec++; if (bus1.sat_o !== msat) begin nerr++; $display("FAIL sat_model@%0d: got %b want %b", k, bus1.sat_o, msat); end
            end
        end
        drain1(nd, idle_ok);
        tick(); tick();
        nvec++; if (bus1.sat_o !== 1'b1) begin nerr++; $display("FAIL sat_sticky: got %b want 1", bus1.sat_o); end
        nvec++; if (bus1.busy_o !== 1'b0) begin nerr++; $display("FAIL sat_idle: got %b want 0", bus1.busy_o); end
        load1(123456, 419430, 11953766, 3000001, -777777, 555555);
        nvec++; if (bus1.sat_o !== 1'b0) begin nerr++; $display("FAIL sat_clear: got %b want 0", bus1.sat_o); end
        nvec++; if (bus1.xn_o !== 32'sd3000001) begin nerr++; $display("FAIL sat_reload_xn: got %0d want 3000001", bus1.xn_o); end
    endtask

    task automatic test_async_reset();
        bus1.start_i = 1'b1;
        tick();
        tick();
        nvec++; if (bus1.busy_o !== 1'b1) begin nerr++; $display("FAIL arst_pre_busy: got %b want 1", bus1.busy_o); end
        #2;
        rst = 1'b1;
        #1;
        nvec++; if (bus1.xn_o !== 32'h00200000) begin nerr++; $display("FAIL arst_xn: got %h want 00200000", bus1.xn_o); end
        nvec++; if (bus1.yn_o !== 32'h0) begin nerr++; $display("FAIL arst_yn: got %h want 0", bus1.yn_o); end
        nvec++; if (bus1.zn_o !== 32'h0) begin nerr++; $display("FAIL arst_zn: got %h want 0", bus1.zn_o); end
        nvec++; if (bus1.busy_o !== 1'b0) begin nerr++; $display("FAIL arst_busy: got %b want 0", bus1.busy_o); end
        nvec++; if (bus1.valid_o !== 1'b0) begin nerr++; $display("FAIL arst_valid: got %b want 0", bus1.valid_o); end
        bus1.start_i = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_decim();
        int nv, last;
        nv = 0;
        last = 0;
        model_reset();
        bus4.start_i = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (bus4.valid_o === 1'b1) begin
                nv++;
                if (nv == 1) begin
                    nvec++; if (k != 13) begin nerr++; $display("FAIL decim_first: got %0d want 13", k); end
                end else begin
                    nvec++; if (k - last != 12) begin nerr++; $display("FAIL decim_spacing: got %0d want 12", k - last); end
                end
                last = k;
                for (int s = 0; s < 4; s++) model_step();
                nvec++; if (bus4.xn_o !== mx[31:0]) begin nerr++; $display("FAIL decim_xn@%0d: got %0d want %0d", k, bus4.xn_o, mx); end
                nvec++; if (bus4.yn_o !== my[31:0]) begin nerr++; $display("FAIL decim_yn@%0d: got %0d want %0d", k, bus4.yn_o, my); end
                nvec++; if (bus4.zn_o !== mz[31:0]) begin nerr++; $display("FAIL decim_zn@%0d: got %0d want %0d", k, bus4.zn_o, mz); end
            end
        end
        nvec++; if (nv != 5) begin nerr++; $display("FAIL decim_count: got %0d want 5", nv); end
        bus4.start_i = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_stop_midrun();
        test_load_busy();
        test_random_golden();
        test_saturation();
        test_async_reset();
        test_decim();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/rossler_gen.md
Name: rossler_gen

Overview:
Parametrised successor to the fixed-width Rossler oscillator. It integrates dx=-y-z, dy=x+a*y, dz=b+z*(x-c) by forward Euler with step h=2^-HShift in signed fixed point. Width and fraction bits are configurable, and a, b, c and the initial state are loadable at run time. It uses one time-shared multiplier, saturating arithmetic, a sticky overflow flag, an output decimator and a valid strobe. It drives DAC/scope and logging paths the same way the current oscillator's xn/yn/zn outputs do.

Parameters:
Width, 32, total bits of every signed fixed-point word.
FracBits, 21, fraction bits (Q(Width-FracBits).FracBits); default SF=2^-21.
HShift, 8, Euler step h=2^-HShift, implemented as an arithmetic right shift.
Decim, 1, number of iterations per published output sample (>=1).
AInit, 419430, reset value of a (0.2 at FracBits=21).
BInit, 419430, reset value of b (0.2).
CInit, 11953766, reset value of c (5.7).
XInit, 2097152, reset value of x (1.0); y and z reset to 0.

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  run enable (level)
load_i  in  1  load-config strobe; honoured only in IDLE
a_i  in  Width  coefficient a
b_i  in  Width  coefficient b
c_i  in  Width  coefficient c
x0_i  in  Width  initial x
y0_i  in  Width  initial y
z0_i  in  Width  initial z
xn_o  out  Width  published x, signed
yn_o  out  Width  published y, signed
zn_o  out  Width  published z, signed
valid_o  out  1  1-cycle strobe, high when a new sample is on xn_o/yn_o/zn_o
busy_o  out  1  high in every state except IDLE
sat_o  out  1  sticky, high once any saturation has occurred

Behaviour:
- Reset (async, rst_i=1): a/b/c = AInit/BInit/CInit; x=XInit, y=z=0; xn_o=XInit, yn_o=zn_o=0; valid_o=0, sat_o=0, busy_o=0; decim counter=0; state=IDLE.
- FSM states: IDLE, MUL_AY, MUL_ZXC, UPDATE.
  - IDLE -> MUL_AY when start_i=1.
  - MUL_AY -> MUL_ZXC -> UPDATE unconditionally.
  - UPDATE -> MUL_AY if start_i=1, else IDLE.
  - One iteration takes 3 clocks.
- MUL_AY: p1 <= mulsat(a, y).
- MUL_ZXC: d = addsat(x, -c); p2 <= mulsat(z, d).
- UPDATE: all three updates use the old x, y, z. Commit simultaneously:
  - x <= addsat(x, ash(addsat(-y, -z)))
  - y <= addsat(y, ash(addsat(x, p1)))
  - z <= addsat(z, ash(addsat(b, p2)))
- ash = arithmetic right shift by HShift (floor rounding).
- mulsat: full 2*Width signed product; take bits [FracBits+Width-1:FracBits] (truncate); saturate to [-2^(Width-1), 2^(Width-1)-1].
- addsat: signed add, saturated to the same range. Negating the most negative value saturates to the maximum.
- Any saturation event sets sat_o; it stays set until reset or an accepted load_i.
- Decimation: the counter increments in UPDATE. When it equals Decim-1 it wraps to 0, xn_o/yn_o/zn_o take the committed x/y/z, and valid_o=1 on the next cycle. Outputs hold between publications.
  - Decim=1: valid_o strobe every 3 clocks.
  - Decim=N: valid_o strobe every 3N clocks.
- start_i falling mid-iteration: the iteration completes, then the FSM returns to IDLE. State and decim counter are retained; a later start_i resumes from them.
- load_i in IDLE with start_i=0:
  - Latches a/b/c and x0/y0/z0 into x/y/z in one clock.
  - Copies x0/y0/z0 to the outputs without pulsing valid_o.
  - Clears the decim counter and sat_o.
- load_i and start_i both high in IDLE: load wins; start is honoured from the next cycle.
- load_i while busy: ignored, with no side effects.

Decomposition:
- Package rossler_pkg holds:
  - fixed-point MAX/MIN constants derived from Width;
  - FSM state encoding;
  - default coefficient constants for FracBits=21.
- Sub-module fxp_mul_sat (signed multiply, rescale by FracBits, saturate, overflow flag) is instantiated once and shared via mux by MUL_AY and MUL_ZXC.
- The addsat helper is a function in rossler_pkg.

Test Plan:
- Reset: rst_i pulse -> xn_o=0x00200000, yn_o=0, zn_o=0, valid_o=0, busy_o=0, sat_o=0.
- Defaults, start_i=1 at cycle 0: first valid_o at cycle 3 -> xn_o=0x00200000, yn_o=0x00002000 (8192), zn_o=0x00000666 (1638). Strobes repeat every 3 clocks.
- Decim=4 build, run 40 clocks: valid_o spacing is exactly 12 clocks. The samples equal every 4th sample of a Decim=1 run.
- Saturation: load x0=0x7FFFFF00, y0=z0=0x80000000, a=0x7FFFFFFF, then start -> x clamps at 0x7FFFFFFF, no wrap, sat_o=1 and sticky. A subsequent load clears it.
- Control: start_i dropped at the MUL_AY cycle -> exactly one more valid_o, then busy_o=0. load_i while busy is ignored (outputs unchanged). Async rst_i mid-MUL_ZXC -> outputs return to reset values immediately.
- Golden compare: 100000 samples with Decim=1 match a bit-accurate software model exactly. Log to file as value*2^-FracBits.
